plm_bank_port_arbiter: RTL
==========================

# plm_bank_port_arbiter

Round-robin arbiter that shares one port of one PLM bank among `NCONSUMERS` requesters. Each cycle it selects at most one eligible request (valid and addressed to this bank), acknowledges it with a same-cycle grant, and issues a registered PLM command. For reads, it routes the PLM read data back to the originating consumer after a fixed latency. One instance sits per bank port between the consumer request bus and the PLM.

## Interface
- `ADDR_WIDTH`, 4: global word-address width in the consumer request.
- `VALUE_WIDTH`, 8: data width.
- `NCONSUMERS`, 2: number of requesters (≥1).
- `NBANKS`, 1: number of banks; power of two. `BANK_BITS = $clog2(NBANKS)`.
- `BANK_ID`, 0: bank served by this instance.
- `READ_LATENCY`, 1: cycles from `plm_en` (read) to valid `plm_rdata`; ≥1.
- Derived widths:
  - `REQ_WIDTH = ADDR_WIDTH+VALUE_WIDTH+2`
  - `LADDR_WIDTH = ADDR_WIDTH-BANK_BITS`
  - `PLM_INPUT_WIDTH = LADDR_WIDTH+VALUE_WIDTH+1`
  - `ID_WIDTH = max(1,$clog2(NCONSUMERS))`

Ports:
- `clk` input 1: the single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `requests` input `[REQ_WIDTH-1:0]` × NCONSUMERS: per-consumer request, packed `{valid, we, addr[ADDR_WIDTH-1:0], value[VALUE_WIDTH-1:0]}`, with `valid` as the MSB.
- `grant` output NCONSUMERS: one-hot or zero; combinational acknowledge.
- `plm_en` output 1: command valid (registered).
- `plm_in` output PLM_INPUT_WIDTH: `{we, local_addr, value}` (registered).
- `plm_rdata` input VALUE_WIDTH: bank read data.
- `resp_valid` output 1: read data valid for `resp_id`.
- `resp_id` output ID_WIDTH: consumer index owning `resp_data`.
- `resp_data` output VALUE_WIDTH: equals `plm_rdata`.

## Operation
- **Bank decode.** Low-order interleaving. Bank = `addr[BANK_BITS-1:0]`; `local_addr = addr[ADDR_WIDTH-1:BANK_BITS]`. When `NBANKS == 1`, every request maps to this bank and `local_addr = addr`.
- **Eligibility.** Consumer i is eligible when its `valid` bit = 1 and its bank = `BANK_ID`. Requests for other banks are never granted here.
- **Arbitration.**
  - State is a pointer `ptr` (ID_WIDTH bits, reset 0).
  - Winner = first eligible index scanning `ptr, ptr+1, …, NCONSUMERS-1, 0, …, ptr-1`.
  - `grant[winner] = 1` combinationally in the same cycle. All other grant bits are 0, and all are 0 when nothing is eligible.
- **Pointer update.** On a grant to w, `ptr <= (w+1) mod NCONSUMERS`. With no grant, `ptr` holds. This guarantees any continuously eligible consumer is granted within NCONSUMERS cycles.
- **Consumer handshake.** The request is consumed at the clock edge ending the cycle in which `grant[i] = 1`. The consumer must hold the request stable until granted and may present a new request in the next cycle. A request whose `valid` drops before grant is simply withdrawn.
- **Command register.** At the edge ending a granted cycle, `plm_en <= 1` and `plm_in <= {we, local_addr, value}` of the winner. Otherwise `plm_en <= 0` and `plm_in` holds.
- **Read tracking.**
  - A shift pipeline of depth READ_LATENCY carries `{is_read, id}`.
  - Its input is `{plm_en & ~plm_in.we, id of the issued command}`, so a read is tracked from the cycle its command appears on `plm_en`.
  - The pipeline output drives `resp_valid` and `resp_id`. `resp_data = plm_rdata` (combinational).
  - Writes produce no response.
- **Reset.** Reset is asynchronous and may arrive mid-operation. It clears `ptr`, `plm_en`, `plm_in`, and the whole read pipeline. In-flight reads are dropped: no `resp_valid` is produced for them. `grant` is forced to 0 while `reset` is high.

## Timing
- Request presented in cycle t → `grant` in cycle t → `plm_en`/`plm_in` in cycle t+1.
- A read granted in t gives `resp_valid`/`resp_id` in cycle t+1+READ_LATENCY.
- Throughput: one command per cycle. Back-to-back grants to different consumers are allowed in consecutive cycles.
- Reset values:
  - `grant = 0`, `plm_en = 0`, `plm_in = 0`, `resp_valid = 0`, `resp_id = 0`, `ptr = 0`.
  - `resp_data` follows `plm_rdata` and has no reset.
- **Wrap-around.** A grant to index NCONSUMERS-1 sets `ptr = 0`.
- **Single consumer.** With `NCONSUMERS = 1`, `ptr` stays 0. Consumer 0 is granted every cycle it is eligible.

## Test plan
- **Reset state.** Assert `reset` asynchronously mid-cycle, with consumer 0 requesting a read issued 0 cycles before → all outputs 0 immediately. No `resp_valid` appears for the dropped read after release.
- **Round-robin with 4 consumers.** NCONSUMERS=4, NBANKS=1, all four hold valid writes → grants 0,1,2,3,0,… in consecutive cycles. `plm_in` lags one cycle with matching addr/value.
- **Pointer skip.** `ptr = 1` (after a grant to 0), only consumers 0 and 3 valid → grant 3, then 0.
- **Bank filter.** NBANKS=2, BANK_ID=1:
  - Consumer 0 request at addr 0x4 → never granted.
  - Consumer 1 request at addr 0x7 → granted; `plm_in` carries local_addr 0x3.
- **Read return.** READ_LATENCY=2, consumer 1 read granted at cycle 10 → `plm_en` at 11 with `we=0`. `resp_valid = 1`, `resp_id = 1` at cycle 13, with `resp_data` equal to `plm_rdata` (drive 0xA5).
- **Mixed stream.** Read(c0), write(c1), read(c1) in cycles 5, 6, 7 with READ_LATENCY=1 → `resp_valid` at 7 (id 0) and 9 (id 1), none at 8.

Source files
------------

// File: rtl/plm_bank_port_arbiter.sv
// Round-robin arbiter sharing one PLM bank port among NCONSUMERS requesters.
// Grants combinationally, issues a registered PLM command and routes read data back by consumer id.
module plm_bank_port_arbiter #(
    parameter int ADDR_WIDTH   = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int NCONSUMERS   = 2,
    parameter int NBANKS       = 1,
    parameter int BANK_ID      = 0,
    parameter int READ_LATENCY = 1,
    localparam int BANK_BITS       = $clog2(NBANKS),
    localparam int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 2,
    localparam int LADDR_WIDTH     = ADDR_WIDTH - BANK_BITS,
    localparam int PLM_INPUT_WIDTH = LADDR_WIDTH + VALUE_WIDTH + 1,
    localparam int ID_WIDTH        = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NCONSUMERS*REQ_WIDTH-1:0] requests,
    output logic [NCONSUMERS-1:0]           grant,
    output logic                            plm_en,
    output logic [PLM_INPUT_WIDTH-1:0]      plm_in,
    input  logic [VALUE_WIDTH-1:0]          plm_rdata,
    output logic                            resp_valid,
    output logic [ID_WIDTH-1:0]             resp_id,
    output logic [VALUE_WIDTH-1:0]          resp_data
);

    // Low-order interleaving: the bank is the masked low address bits.
    localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NBANKS - 1);
    localparam logic [ADDR_WIDTH-1:0] BANK_SEL  = ADDR_WIDTH'(BANK_ID);

    logic [NCONSUMERS-1:0][REQ_WIDTH-1:0] req_arr_s;
    logic [NCONSUMERS-1:0]                elig_s;
    logic [NCONSUMERS-1:0]                grant_s;
    logic                                 found_s;
    logic                                 hit_s;
    logic [ID_WIDTH-1:0]                  win_id_s;
    logic [PLM_INPUT_WIDTH-1:0]           cmd_s;

    logic [ID_WIDTH-1:0]        ptr_q, ptr_d;
    logic                       plm_en_q, plm_en_d;
    logic [PLM_INPUT_WIDTH-1:0] plm_in_q, plm_in_d;
    logic [ID_WIDTH-1:0]        cmd_id_q, cmd_id_d;
    logic [READ_LATENCY-1:0]    rd_v_q;
    logic [ID_WIDTH-1:0]        rd_id_q [READ_LATENCY];

    // Split the flat request bus and flag requests that target this bank.
    always_comb begin
        req_arr_s = requests;
        elig_s    = '0;
        for (int i = 0; i < NCONSUMERS; i++) begin
            elig_s[i] = req_arr_s[i][REQ_WIDTH-1] &
                        ((req_arr_s[i][VALUE_WIDTH +: ADDR_WIDTH] & BANK_MASK) == BANK_SEL);
        end
    end

    // Scan offsets ptr, ptr+1, ... and keep the first eligible consumer.
    always_comb begin
        grant_s  = '0;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        win_id_s = '0;
        cmd_s    = '0;
        for (int k = 0; k < NCONSUMERS; k++) begin
            for (int i = 0; i < NCONSUMERS; i++) begin
                hit_s = ~found_s & elig_s[i] &
                        ((int'(ptr_q) + k == i) | (int'(ptr_q) + k == i + NCONSUMERS));
                found_s    = found_s | hit_s;
                grant_s[i] = grant_s[i] | hit_s;
                win_id_s   = hit_s ? ID_WIDTH'(i) : win_id_s;
                cmd_s      = hit_s ? {req_arr_s[i][REQ_WIDTH-2],
                                      LADDR_WIDTH'(req_arr_s[i][VALUE_WIDTH +: ADDR_WIDTH] >> BANK_BITS),
                                      req_arr_s[i][VALUE_WIDTH-1:0]}
                                   : cmd_s;
            end
        end
    end

    // Next-state for pointer and command register; both hold when nothing wins.
    always_comb begin
        ptr_d    = found_s ? ((win_id_s == ID_WIDTH'(NCONSUMERS - 1)) ? '0 : win_id_s + ID_WIDTH'(1))
                           : ptr_q;
        plm_en_d = found_s;
        plm_in_d = found_s ? cmd_s : plm_in_q;
        cmd_id_d = found_s ? win_id_s : cmd_id_q;
    end

    // Arbiter state, command register and read-tracking pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            plm_en_q <= 1'b0;
            plm_in_q <= '0;
            cmd_id_q <= '0;
            rd_v_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_id_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            plm_en_q   <= plm_en_d;
            plm_in_q   <= plm_in_d;
            cmd_id_q   <= cmd_id_d;
            rd_v_q[0]  <= plm_en_q & ~plm_in_q[PLM_INPUT_WIDTH-1];
            rd_id_q[0] <= cmd_id_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_v_q[i]  <= rd_v_q[i-1];
                rd_id_q[i] <= rd_id_q[i-1];
            end
        end
    end

    assign grant      = reset ? '0 : grant_s;
    assign plm_en     = plm_en_q;
    assign plm_in     = plm_in_q;
    assign resp_valid = rd_v_q[READ_LATENCY-1];
    assign resp_id    = rd_id_q[READ_LATENCY-1];
    assign resp_data  = plm_rdata;

endmodule
